// File: rtl/restoring_divider.sv
// ---------------------------------------------------------------------------
// restoring_divider
//   Sequential unsigned restoring divider: q = a / b, r = a % b.
//   One quotient bit is resolved per clock with a (WIDTH+1)-bit trial
//   subtraction. Results are published with a one-cycle done pulse and held
//   until the next accepted start. A zero divisor bypasses the iteration and
//   reports q = all ones, r = a, div_zero = 1.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      division request, honoured only when idle
//   a         in   WIDTH  dividend, captured on the accepted start
//   b         in   WIDTH  divisor, captured on the accepted start
//   busy      out  1      division iterating
//   done      out  1      one-cycle pulse, q/r/div_zero valid from here on
//   q         out  WIDTH  quotient
//   r         out  WIDTH  remainder
//   div_zero  out  1      last division had b == 0
// ---------------------------------------------------------------------------
module restoring_divider #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] quo_q, quo_d;       // working quotient / shifted dividend
   logic [WIDTH-1:0] rem_q, rem_d;       // working partial remainder
   logic [WIDTH-1:0] dvs_q, dvs_d;       // latched divisor
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dz_q, dz_d;         // pending div-by-zero flag
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             div_zero_q, div_zero_d;

   // Shifted remainder keeps R's old MSB as bit WIDTH of the trial operand.
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic             no_borrow;

   // Trial subtract rem_sh - D as rem_sh + ~D + 1. Because R < D always
   // holds, the difference lies in (-2^WIDTH, 2^WIDTH), so bit WIDTH is an
   // exact sign bit.
   always_comb begin
      rem_sh    = {rem_q, quo_q[WIDTH-1]};
      trial     = rem_sh + ~{1'b0, dvs_q} + (WIDTH+1)'(1);
      no_borrow = ~trial[WIDTH];
   end

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      dvs_d      = dvs_q;
      cnt_d      = cnt_q;
      dz_d       = dz_q;
      q_d        = q_q;
      r_d        = r_q;
      div_zero_d = div_zero_q;
      busy_d     = (state_q == S_RUN);
      done_d     = (state_q == S_DONE);

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               div_zero_d = 1'b0;
               if (b == '0) begin
                  state_d = S_DONE;
                  quo_d   = '1;
                  rem_d   = a;
                  dz_d    = 1'b1;
               end else begin
                  state_d = S_RUN;
                  quo_d   = a;
                  dvs_d   = b;
                  rem_d   = '0;
                  cnt_d   = CW'(WIDTH);
                  dz_d    = 1'b0;
               end
            end
         end
         S_RUN: begin
            quo_d = {quo_q[WIDTH-2:0], no_borrow};
            rem_d = no_borrow ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d    = S_IDLE;
            q_d        = quo_q;
            r_d        = rem_q;
            div_zero_d = dz_q;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         quo_q      <= '0;
         rem_q      <= '0;
         dvs_q      <= '0;
         cnt_q      <= '0;
         dz_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         q_q        <= '0;
         r_q        <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         dvs_q      <= dvs_d;
         cnt_q      <= cnt_d;
         dz_q       <= dz_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         q_q        <= q_d;
         r_q        <= r_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign q        = q_q;
   assign r        = r_q;
   assign div_zero = div_zero_q;

endmodule
